// File: rtl/xl_link_ctrl.sv
// Link bring-up sequencer: frames a test pattern onto the detector check line
// and scores the detector's flag pulses over a programmable number of frames.
module xl_link_ctrl #(
  parameter logic [7:0]  PAT     = 8'b0010_0010,
  parameter int unsigned PAT_LEN = 8,
  parameter int unsigned GUARD   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n_frames,
  input  logic       flag_in,
  output logic       ser_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err,
  output logic [3:0] hit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GUARD = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] GUARD_LD = 8'(GUARD - 1);
  localparam logic [7:0] TMO_LD   = 8'(TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = 3'(8 - PAT_LEN);

  state_t     state_r, state_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  logic [7:0] tmo_r, tmo_s;     // shared down-counter for GUARD and WAIT
  logic [3:0] frm_r, frm_s;     // frames remaining
  logic [3:0] nfr_r, nfr_s;     // frames requested, kept for scoring
  logic [3:0] hit_s;
  logic       err_s, pass_s, ser_s, busy_s, done_s;

  // Next-state, counter and output-value decode
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    tmo_s     = tmo_r;
    frm_s     = frm_r;
    nfr_s     = nfr_r;
    hit_s     = hit_cnt;
    err_s     = err;
    pass_s    = pass;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          nfr_s   = (n_frames == 4'd0) ? 4'd1 : n_frames;
          frm_s   = (n_frames == 4'd0) ? 4'd1 : n_frames;
          hit_s   = 4'd0;
          err_s   = 1'b0;
          pass_s  = 1'b0;
          tmo_s   = GUARD_LD;
          state_s = S_GUARD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_GUARD: begin
        err_s = err | flag_in;
        if (tmo_r == 8'd0) begin
          bit_idx_s = 3'd7;
          state_s   = S_SEND;
        end else begin
          tmo_s = tmo_r - 8'd1;
        end
      end
      S_SEND: begin
        err_s = err | flag_in;
        if (bit_idx_r == LAST_IDX) begin
          tmo_s   = TMO_LD;
          state_s = S_WAIT;
        end else begin
          bit_idx_s = bit_idx_r - 3'd1;
        end
      end
      S_WAIT: begin
        // a flag on the expiring cycle still counts as a hit
        if (flag_in || (tmo_r == 8'd0)) begin
          if (flag_in && (hit_cnt != 4'd15)) begin
            hit_s = hit_cnt + 4'd1;
          end else begin
            hit_s = hit_cnt;
          end
          frm_s = frm_r - 4'd1;
          if (frm_r == 4'd1) begin
            pass_s  = (hit_s == nfr_r) && !err;
            state_s = S_DONE;
          end else begin
            tmo_s   = GUARD_LD;
            state_s = S_GUARD;
          end
        end else begin
          tmo_s = tmo_r - 8'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    ser_s  = (state_s == S_SEND) ? PAT[bit_idx_s] : 1'b1;
    busy_s = (state_s != S_IDLE);
    done_s = (state_s == S_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      bit_idx_r <= 3'd7;
      tmo_r     <= 8'd0;
      frm_r     <= 4'd0;
      nfr_r     <= 4'd0;
      ser_out   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= 1'b0;
      hit_cnt   <= 4'd0;
    end else begin
      state_r   <= state_s;
      bit_idx_r <= bit_idx_s;
      tmo_r     <= tmo_s;
      frm_r     <= frm_s;
      nfr_r     <= nfr_s;
      ser_out   <= ser_s;
      busy      <= busy_s;
      done      <= done_s;
      pass      <= pass_s;
      err       <= err_s;
      hit_cnt   <= hit_s;
    end
  end

endmodule

// File: doc/xl_link_ctrl.md
# xl_link_ctrl

Sequencing controller for the serial pattern-detector link. It drives the detector's serial `check` line with framed test patterns and counts the detector's `flag` pulses. It reports pass/fail after a programmable number of frames. It sits between a host/test register interface and the serial receiver, and is used for link bring-up and self-test.

## Interface
- `PAT`, 8'b0010_0010, serial pattern sent MSB first; default is the detector's target sequence.
- `PAT_LEN`, 8, number of pattern bits sent (1..8, taken from `PAT[7:8-PAT_LEN]`).
- `GUARD`, 4, idle-one cycles before each frame (min 3, forces detector into its all-ones state).
- `TIMEOUT`, 8, cycles to wait for `flag_in` after the last pattern bit (1..255).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request; sampled only in IDLE.
- `n_frames` input 4: frames per run, latched on accepted `start`; 0 is treated as 1.
- `flag_in` input 1: detector match flag.
- `ser_out` output 1: serial line to detector `check` input, registered.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse at run end.
- `pass` output 1: result of last run, held until next accepted `start`.
- `err` output 1: sticky spurious-flag indicator for the current run.
- `hit_cnt` output 4: flags counted in WAIT windows for the current run.

## Operation
- States: IDLE, GUARD, SEND, WAIT, DONE; 3-bit state register plus bit counter (3 b), timeout counter (8 b) and frame counter (4 b).
- IDLE: `ser_out`=1, `busy`=0. On `start`=1: latch `n_frames` (0→1), clear `hit_cnt`, `err`, `pass`, load GUARD count, go to GUARD.
- GUARD: `ser_out`=1 for exactly `GUARD` cycles, then go to SEND with bit index = 7.
- SEND: `ser_out`=`PAT[idx]` for one cycle per bit, `PAT_LEN` cycles total, then go to WAIT and load TIMEOUT.
- WAIT: `ser_out`=1.
  - First `flag_in`=1 in the window: increment `hit_cnt` (saturate at 15) and end the window immediately.
  - Otherwise the window ends when the timeout counter expires.
  - At window end: decrement frames remaining. If frames remain, go to GUARD; else go to DONE.
  - Only one hit is counted per frame.
- `flag_in`=1 during GUARD or SEND sets `err`. It is not counted in `hit_cnt`.
- DONE: one cycle. Assert `done`=1. Set `pass`=1 iff `hit_cnt`==frames latched and `err`=0. Return to IDLE.
- `start` while `busy` is ignored, with no effect on counters.
- Reset values: `ser_out`=1, `busy`=0, `done`=0, `pass`=0, `err`=0, `hit_cnt`=0, state IDLE. Reset mid-run aborts immediately, with no `done` pulse.
- Default parameters produce exactly one detector flag per frame. GUARD ones drive the detector to its all-ones state. The first 0 returns it to start, and the remaining 7 bits walk it to the match state.

## Timing
- `start` accepted at edge k: `busy`=1 and GUARD begin at k+1.
- First pattern bit appears on `ser_out` at k+1+GUARD.
- Frame length without a hit is GUARD+PAT_LEN+TIMEOUT cycles. A hit shortens WAIT to (cycles until flag)+1.
- Detector flag latency is 2 cycles after the last bit is on `ser_out`. With TIMEOUT=8 there is margin for 6 extra cycles.
- `done` is asserted in the cycle after the final WAIT. `busy` drops together with `done` going low (IDLE).
- `pass`, `hit_cnt`, `err` are stable from the `done` cycle until the next accepted `start`.
- Simultaneous timeout expiry and `flag_in`=1 in the last WAIT cycle counts as a hit.

## Test plan
- Reset mid-SEND (`rst` pulse async) → `ser_out`=1, `busy`=0, `hit_cnt`=0, no `done`. A following `start`, `n_frames`=1 with the detector attached → `pass`=1.
- `start`, `n_frames`=3, detector attached, defaults → 3 frames of 4 ones + 00100010. `hit_cnt`=3, `pass`=1, `err`=0, `done` one cycle.
- `n_frames`=2, `flag_in` tied 0 → each frame lasts 4+8+8=20 cycles. `done` at cycle 41 after `start`, `hit_cnt`=0, `pass`=0.
- `flag_in` forced 1 during the 2nd SEND bit of frame 1, `n_frames`=1 → `err`=1, `pass`=0 even if WAIT hit gives `hit_cnt`=1.
- `start` re-pulsed while `busy` with `n_frames`=5 during a 1-frame run → ignored. Run ends after 1 frame, `hit_cnt`=1.
- `n_frames`=0 → behaves as 1: one frame, `pass`=1 with detector attached. Also check `flag_in` arriving in the last WAIT cycle (TIMEOUT=2 build) counts as a hit.
